// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - MEM stage op/state encodings and decode helpers
// MEM_UNALIGNED_LR_EN adds LWL/LWR/SWL/SWR to the memory-op decode.
package mem_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_LWL  = 4'd9;
  localparam logic [3:0] OP_LWR  = 4'd10;
  localparam logic [3:0] OP_SWL  = 4'd11;
  localparam logic [3:0] OP_SWR  = 4'd12;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    logic r;
    r = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
`ifdef MEM_UNALIGNED_LR_EN
    r = r | (op inside {OP_LWL, OP_LWR});
`endif
    return r;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    logic r;
    r = op inside {OP_SB, OP_SH, OP_SW};
`ifdef MEM_UNALIGNED_LR_EN
    r = r | (op inside {OP_SWL, OP_SWR});
`endif
    return r;
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    return is_load(op) | is_store(op);
  endfunction

  // LWL/LWR/SWL/SWR are never misaligned, so they are absent here
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    return ((op inside {OP_LH, OP_LHU, OP_SH}) && a[0]) ||
           ((op inside {OP_LW, OP_SW}) && (a != 2'b00));
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    logic [1:0] s;
    case (op)
      OP_LH, OP_LHU, OP_SH:                        s = SIZE_HALF;
      OP_LW, OP_SW, OP_LWL, OP_LWR, OP_SWL, OP_SWR: s = SIZE_WORD;
      default:                                     s = SIZE_BYTE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - SRAM-like request/response data bus
// master drives requests (MEM stage), slave answers (memory system).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian byte-lane steering for loads and stores
// MEM_UNALIGNED_LR_EN adds the LWL/LWR merge and SWL/SWR strobe/shift paths.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] reg2_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  sh;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign sh    = {a_i, 3'b000};
  assign rbyte = 8'(rdata_i >> sh);
  assign rhalf = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];

`ifdef MEM_UNALIGNED_LR_EN
  // 24 - 8k, with k = addr[1:0]
  logic [4:0] nsh;
  assign nsh = {~a_i, 3'b000};
`endif

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = 32'h0;
    rdata_o = rdata_i;
    case (op_i)
      OP_LB:  rdata_o = {{24{rbyte[7]}}, rbyte};
      OP_LBU: rdata_o = {24'h0, rbyte};
      OP_LH:  rdata_o = {{16{rhalf[15]}}, rhalf};
      OP_LHU: rdata_o = {16'h0, rhalf};
      OP_SB: begin
        wstrb_o = 4'b0001 << a_i;
        wdata_o = {4{reg2_i[7:0]}};
      end
      OP_SH: begin
        wstrb_o = a_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{reg2_i[15:0]}};
      end
      OP_SW: begin
        wstrb_o = 4'b1111;
        wdata_o = reg2_i;
      end
`ifdef MEM_UNALIGNED_LR_EN
      OP_LWL: rdata_o = (rdata_i << nsh) | (reg2_i & (32'h00FF_FFFF >> sh));
      OP_LWR: rdata_o = (rdata_i >> sh) | (reg2_i & ~(32'hFFFF_FFFF >> sh));
      OP_SWL: begin
        wstrb_o = 4'b1111 >> (~a_i);
        wdata_o = reg2_i >> nsh;
      end
      OP_SWR: begin
        wstrb_o = 4'b1111 << a_i;
        wdata_o = reg2_i << sh;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS32 MEM stage over an SRAM-like req/resp bus
// MEM_UNALIGNED_LR_EN enables LWL/LWR/SWL/SWR with word-aligned bus addresses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       alu_data_i,
  output logic              stall_o,
  mem_access_unit_if.master bus,
  output logic              wb_valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] badvaddr_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       reg2_q, reg2_d;
  logic [4:0]        wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic              flush_q, flush_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_wd_q, wb_wd_d;
  logic              wb_wreg_q, wb_wreg_d;
  logic [31:0]       wb_wdata_q, wb_wdata_d;
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;
  logic              bus_err_q, bus_err_d;
  logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;

  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        accept_mem;
  logic        finish;
  logic        timeout;
  logic        flushed;

  mem_lane_align u_lane (
    .op_i    (op_q),
    .a_i     (addr_q[1:0]),
    .rdata_i (bus.data_rdata),
    .reg2_i  (reg2_q),
    .wstrb_o (lane_wstrb),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  assign accept_mem = valid_i && !flush_i && is_mem(op_i) && !misaligned(op_i, addr_i[1:0]);
  assign flushed    = flush_q || flush_i;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    reg2_d     = reg2_q;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    flush_d    = flush_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_wd_d    = wb_wd_q;
    wb_wreg_d  = 1'b0;
    wb_wdata_d = wb_wdata_q;
    adel_d     = 1'b0;
    ades_d     = 1'b0;
    bus_err_d  = 1'b0;
    badvaddr_d = badvaddr_q;
    finish     = 1'b0;
    timeout    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          if (!is_mem(op_i)) begin
            wb_valid_d = 1'b1;
            wb_wd_d    = wd_i;
            wb_wreg_d  = wreg_i;
            wb_wdata_d = alu_data_i;
          end else if (misaligned(op_i, addr_i[1:0])) begin
            adel_d     = is_load(op_i);
            ades_d     = is_store(op_i);
            badvaddr_d = addr_i;
            wb_wd_d    = wd_i;
          end else begin
            op_d    = op_i;
            addr_d  = addr_i;
            reg2_d  = reg2_i;
            wd_d    = wd_i;
            wreg_d  = wreg_i && is_load(op_i);
            flush_d = 1'b0;
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        flush_d = flushed;
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) finish = 1'b1;
          else                  state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        flush_d = flushed;
        cnt_d   = cnt_q + 1'b1;
        if (bus.data_data_ok) finish = 1'b1;
        else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) timeout = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A flushed transaction still completes on the bus but never retires
    if (finish || timeout) begin
      state_d    = ST_RESP;
      wb_valid_d = !flushed;
      wb_wreg_d  = wreg_q && !flushed && !timeout;
      wb_wd_d    = wd_q;
      wb_wdata_d = lane_rdata;
      bus_err_d  = timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NONE;
      addr_q     <= '0;
      reg2_q     <= '0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      flush_q    <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_wd_q    <= '0;
      wb_wreg_q  <= 1'b0;
      wb_wdata_q <= '0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      badvaddr_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      reg2_q     <= reg2_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
      adel_q     <= adel_d;
      ades_q     <= ades_d;
      bus_err_q  <= bus_err_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  assign stall_o = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                   ((state_q == ST_IDLE) && accept_mem);

  assign bus.data_req   = (state_q == ST_REQ);
  assign bus.data_wr    = (state_q == ST_REQ) && is_store(op_q);
  assign bus.data_size  = op_size(op_q);
  assign bus.data_wstrb = lane_wstrb;
  assign bus.data_wdata = lane_wdata;
`ifdef MEM_UNALIGNED_LR_EN
  assign bus.data_addr  = (op_q inside {OP_LWL, OP_LWR, OP_SWL, OP_SWR}) ?
                          (addr_q & ~ADDR_W'(3)) : addr_q;
`else
  assign bus.data_addr  = addr_q;
`endif

  assign wb_valid_o = wb_valid_q;
  assign wd_o       = wb_wd_q;
  assign wreg_o     = wb_wreg_q;
  assign wdata_o    = wb_wdata_q;
  assign adel_o     = adel_q;
  assign ades_o     = ades_q;
  assign bus_err_o  = bus_err_q;
  assign badvaddr_o = badvaddr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit
// Exercises LWL/LWR/SWL/SWR when built with MEM_UNALIGNED_LR_EN.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, flush_i;
  logic [3:0]  op_i;
  logic [31:0] addr_i, reg2_i, alu_data_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        stall_o, wb_valid_o, wreg_o, adel_o, ades_o, bus_err_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o, badvaddr_o;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .op_i(op_i),
    .addr_i(addr_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .alu_data_i(alu_data_i), .stall_o(stall_o), .bus(bus),
    .wb_valid_o(wb_valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .adel_o(adel_o), .ades_o(ades_o), .bus_err_o(bus_err_o), .badvaddr_o(badvaddr_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr, reg2, alu;
    logic        wreg;
    logic [31:0] rdata;
    int          dly;
    bit          same;
    bit          busop;
    logic [3:0]  strb;
    logic [31:0] bwdata, baddr;
    logic [1:0]  size;
    logic        ewreg;
    logic [31:0] ewdata;
    logic        adel, ades;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [3:0] op, logic [31:0] addr, logic [31:0] reg2,
                              logic [31:0] alu, logic wreg, logic [31:0] rdata, int dly, bit same,
                              bit busop, logic [3:0] strb, logic [31:0] bwdata, logic [31:0] baddr,
                              logic [1:0] size, logic ewreg, logic [31:0] ewdata,
                              logic adel, logic ades);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.reg2 = reg2; v.alu = alu; v.wreg = wreg;
    v.rdata = rdata; v.dly = dly; v.same = same; v.busop = busop; v.strb = strb;
    v.bwdata = bwdata; v.baddr = baddr; v.size = size; v.ewreg = ewreg; v.ewdata = ewdata;
    v.adel = adel; v.ades = ades;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    bit  done;
    logic [4:0] wd;
    wd = 5'(idx + 1);
    valid_i = 1'b1; op_i = v.op; addr_i = v.addr; reg2_i = v.reg2;
    wd_i = wd; wreg_i = v.wreg; alu_data_i = v.alu;
    #1;
    check({v.name, "_stall0"}, 32'(stall_o), 32'(v.busop));
    step();
    if (!v.busop) begin
      valid_i = 1'b0;
      check({v.name, "_req"}, 32'(bus.data_req), 32'd0);
      check({v.name, "_adel"}, 32'(adel_o), 32'(v.adel));
      check({v.name, "_ades"}, 32'(ades_o), 32'(v.ades));
      check({v.name, "_wreg"}, 32'(wreg_o), 32'(v.ewreg));
      if (v.adel || v.ades) begin
        check({v.name, "_badv"}, badvaddr_o, v.addr);
      end else begin
        check({v.name, "_wbv"}, 32'(wb_valid_o), 32'd1);
        check({v.name, "_wd"}, 32'(wd_o), 32'(wd));
        check({v.name, "_wdata"}, wdata_o, v.ewdata);
      end
    end else begin
      check({v.name, "_req"}, 32'(bus.data_req), 32'd1);
      check({v.name, "_wr"}, 32'(bus.data_wr), 32'(v.strb != 4'b0000));
      check({v.name, "_size"}, 32'(bus.data_size), 32'(v.size));
      check({v.name, "_addr"}, bus.data_addr, v.baddr);
      check({v.name, "_strb"}, 32'(bus.data_wstrb), 32'(v.strb));
      check({v.name, "_bwdata"}, bus.data_wdata, v.bwdata);
      n = 1;
      done = 1'b0;
      while (!done && n < 40) begin
        bus.data_addr_ok = (n == 1 + v.dly);
        bus.data_data_ok = (v.same && n == 1 + v.dly) || (!v.same && n == 2 + v.dly);
        bus.data_rdata   = v.rdata;
        step();
        n++;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        if (wb_valid_o) done = 1'b1;
      end
      check({v.name, "_latency"}, 32'(n), v.same ? 32'(2 + v.dly) : 32'(3 + v.dly));
      check({v.name, "_wreg"}, 32'(wreg_o), 32'(v.ewreg));
      check({v.name, "_respstall"}, 32'(stall_o), 32'd0);
      if (v.ewreg) begin
        check({v.name, "_wd"}, 32'(wd_o), 32'(wd));
        check({v.name, "_wdata"}, wdata_o, v.ewdata);
      end
      valid_i = 1'b0;
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000001 expected 0x00000000");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; op_i = '0; addr_i = '0; reg2_i = '0;
    wd_i = '0; wreg_i = 1'b0; alu_data_i = '0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
    step(); step();

    check("rst_wbv", 32'(wb_valid_o), 32'd0);
    check("rst_wreg", 32'(wreg_o), 32'd0);
    check("rst_wd", 32'(wd_o), 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_req", 32'(bus.data_req), 32'd0);
    check("rst_wr", 32'(bus.data_wr), 32'd0);
    check("rst_daddr", bus.data_addr, 32'd0);
    check("rst_dwdata", bus.data_wdata, 32'd0);
    check("rst_strb", 32'(bus.data_wstrb), 32'd0);
    check("rst_size", 32'(bus.data_size), 32'd0);
    check("rst_exc", {29'd0, adel_o, ades_o, bus_err_o}, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    rst = 1'b0;
    step();

    vecs.push_back(mk("pass_none", OP_NONE, 32'h0, 32'h0, 32'h1234_5678, 1'b1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h1234_5678, 0, 0));
    vecs.push_back(mk("pass_op13", 4'd13, 32'h5, 32'h0, 32'h0BAD_F00D, 1'b1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0BAD_F00D, 0, 0));
    vecs.push_back(mk("lb", OP_LB, 32'h1003, 32'h0, 32'h0, 1'b1, 32'h80FF_0000, 0, 0, 1, 4'h0, 32'h0, 32'h1003, 2'd0, 1'b1, 32'hFFFF_FF80, 0, 0));
    vecs.push_back(mk("lbu", OP_LBU, 32'h1002, 32'h0, 32'h0, 1'b1, 32'h80FF_7F00, 2, 0, 1, 4'h0, 32'h0, 32'h1002, 2'd0, 1'b1, 32'h0000_00FF, 0, 0));
    vecs.push_back(mk("lh", OP_LH, 32'h1002, 32'h0, 32'h0, 1'b1, 32'h80FF_0000, 0, 1, 1, 4'h0, 32'h0, 32'h1002, 2'd1, 1'b1, 32'hFFFF_80FF, 0, 0));
    vecs.push_back(mk("lhu", OP_LHU, 32'h1000, 32'h0, 32'h0, 1'b1, 32'h80FF_8001, 1, 0, 1, 4'h0, 32'h0, 32'h1000, 2'd1, 1'b1, 32'h0000_8001, 0, 0));
    vecs.push_back(mk("lw", OP_LW, 32'h1004, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 0, 1, 1, 4'h0, 32'h0, 32'h1004, 2'd2, 1'b1, 32'hDEAD_BEEF, 0, 0));
    vecs.push_back(mk("sb", OP_SB, 32'h2001, 32'h1234_56A5, 32'h0, 1'b0, 32'h0, 0, 0, 1, 4'b0010, 32'hA5A5_A5A5, 32'h2001, 2'd0, 1'b0, 32'h0, 0, 0));
    vecs.push_back(mk("sh", OP_SH, 32'h2002, 32'h1234_ABCD, 32'h0, 1'b0, 32'h0, 0, 0, 1, 4'b1100, 32'hABCD_ABCD, 32'h2002, 2'd1, 1'b0, 32'h0, 0, 0));
    vecs.push_back(mk("sw", OP_SW, 32'h2000, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0, 3, 0, 1, 4'b1111, 32'hCAFE_F00D, 32'h2000, 2'd2, 1'b0, 32'h0, 0, 0));
    vecs.push_back(mk("lw_misal", OP_LW, 32'h3001, 32'h0, 32'h0, 1'b1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 1, 0));
    vecs.push_back(mk("sh_misal", OP_SH, 32'h2003, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 0, 1));
    vecs.push_back(mk("lh_misal", OP_LH, 32'h1001, 32'h0, 32'h0, 1'b1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 1, 0));
    vecs.push_back(mk("sw_misal", OP_SW, 32'h2002, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 0, 1));
`ifdef MEM_UNALIGNED_LR_EN
    vecs.push_back(mk("lwl", OP_LWL, 32'h11, 32'hAABB_CCDD, 32'h0, 1'b1, 32'h4433_2211, 0, 0, 1, 4'h0, 32'h0, 32'h10, 2'd2, 1'b1, 32'h2211_CCDD, 0, 0));
    vecs.push_back(mk("lwr", OP_LWR, 32'h11, 32'hAABB_CCDD, 32'h0, 1'b1, 32'h4433_2211, 1, 0, 1, 4'h0, 32'h0, 32'h10, 2'd2, 1'b1, 32'hAA44_3322, 0, 0));
    vecs.push_back(mk("swl", OP_SWL, 32'h11, 32'hAABB_CCDD, 32'h0, 1'b0, 32'h0, 0, 0, 1, 4'b0011, 32'h0000_AABB, 32'h10, 2'd2, 1'b0, 32'h0, 0, 0));
    vecs.push_back(mk("swr", OP_SWR, 32'h12, 32'hAABB_CCDD, 32'h0, 1'b0, 32'h0, 0, 0, 1, 4'b1100, 32'hCCDD_0000, 32'h10, 2'd2, 1'b0, 32'h0, 0, 0));
`else
    vecs.push_back(mk("lwl_pass", OP_LWL, 32'h11, 32'hAABB_CCDD, 32'h0000_0099, 1'b1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0000_0099, 0, 0));
    vecs.push_back(mk("swr_pass", OP_SWR, 32'h12, 32'hAABB_CCDD, 32'h0000_0077, 1'b1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0000_0077, 0, 0));
`endif

    foreach (vecs[i]) run_vec(vecs[i], i);

    // LHU with addr_ok delayed 4 cycles and a flush pulse while in REQ
    valid_i = 1'b1; op_i = OP_LHU; addr_i = 32'h1002; wreg_i = 1'b1; wd_i = 5'd9;
    step();
    for (int c = 1; c <= 5; c++) begin
      bus.data_addr_ok = (c == 5);
      flush_i = (c == 2);
      #1;
      check("flush_req_held", 32'(bus.data_req), 32'd1);
      step();
    end
    bus.data_addr_ok = 1'b0; flush_i = 1'b0;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5555_AAAA;
    step();
    bus.data_data_ok = 1'b0;
    check("flush_wbv", 32'(wb_valid_o), 32'd0);
    check("flush_wreg", 32'(wreg_o), 32'd0);
    check("flush_stall", 32'(stall_o), 32'd0);
    valid_i = 1'b0;
    step();

    // Watchdog: data_ok never arrives
    valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h40; wreg_i = 1'b1;
    step();
    bus.data_addr_ok = 1'b1;
    step();
    bus.data_addr_ok = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      check("to_early", 32'(bus_err_o), 32'd0);
      step();
    end
    check("to_pulse", 32'(bus_err_o), 32'd1);
    check("to_wreg", 32'(wreg_o), 32'd0);
    valid_i = 1'b0;
    step();
    check("to_clear", 32'(bus_err_o), 32'd0);
    check("to_idle_stall", 32'(stall_o), 32'd0);

    // valid_i low retires nothing
    valid_i = 1'b1; op_i = OP_NONE; alu_data_i = 32'h7; wreg_i = 1'b1;
    step();
    valid_i = 1'b0;
    check("v0_first", 32'(wb_valid_o), 32'd1);
    step();
    check("v0_after", 32'(wb_valid_o), 32'd0);

    // Reset in the middle of a request
    valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h50;
    step();
    check("rstmid_req", 32'(bus.data_req), 32'd1);
    rst = 1'b1; valid_i = 1'b0;
    step();
    rst = 1'b0;
    check("rstmid_req0", 32'(bus.data_req), 32'd0);
    check("rstmid_stall", 32'(stall_o), 32'd0);
    check("rstmid_addr", bus.data_addr, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
